// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-requester memory port arbiter.
package mem_arb_pkg;

  // Arbiter ownership state: free, or held by one requester for a burst.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  // Requester identifiers carried through the read-return pipeline.
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // One in-flight access slot: valid marks a read, id names its issuer.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  localparam rd_tag_t TAG_NONE = '{valid: 1'b0, id: 1'b0};

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Increment a 16-bit counter, sticking at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register that follows each access through the memory's
// read latency so returning data can be steered to its issuer.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [0:DEPTH-1];
  rd_tag_t stage_d [0:DEPTH-1];

  // Next stage contents: new tag enters at the head, the rest shift by one.
  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Tag storage; reset discards every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= TAG_NONE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between requester A (accelerator) and
// requester B (UART controller): round-robin by default, optional burst
// locking with a bounded starvation timeout, and read data returned to the
// requester that issued the read after the fixed memory latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int LOCK_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_lock,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_lock,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dw,
  input  logic [DATA_WIDTH-1:0] mem_dr,
  output logic [15:0]           conflict_cnt
);

  // A zero timeout means a lock may be held indefinitely.
  localparam logic        TIMEOUT_EN = (LOCK_TIMEOUT > 0);
  localparam logic [15:0] LOCK_LIMIT = 16'(LOCK_TIMEOUT);

  arb_state_t            state_q, state_d;
  logic                  last_winner_q, last_winner_d;
  logic [15:0]           lock_cnt_q, lock_cnt_d;
  logic [15:0]           conflict_cnt_q, conflict_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dw_q, dw_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  logic       rr_a_s, rr_b_s;
  logic       timeout_a_s, timeout_b_s;
  logic       arb_a_s, arb_b_s;
  logic       gnt_a_s, gnt_b_s;
  logic       we_s;
  arb_state_t idle_next_s;
  rd_tag_t    tag_in_s, tag_out_s;

  // Grant selection: round-robin when free, owner-only when locked, and the
  // waiting side forced through once a lock has starved it long enough.
  always_comb begin
    rr_a_s      = a_req && (!b_req || (last_winner_q == ID_B));
    rr_b_s      = b_req && !rr_a_s;
    timeout_a_s = TIMEOUT_EN && (lock_cnt_q == LOCK_LIMIT) && b_req;
    timeout_b_s = TIMEOUT_EN && (lock_cnt_q == LOCK_LIMIT) && a_req;

    if (rr_a_s && a_lock) begin
      idle_next_s = LOCK_A;
    end else if (rr_b_s && b_lock) begin
      idle_next_s = LOCK_B;
    end else begin
      idle_next_s = IDLE;
    end

    arb_a_s = 1'b0;
    arb_b_s = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        arb_a_s = rr_a_s;
        arb_b_s = rr_b_s;
        state_d = idle_next_s;
      end
      LOCK_A: begin
        if (!a_lock) begin
          // Owner released the lock: this cycle is arbitrated as if free.
          arb_a_s = rr_a_s;
          arb_b_s = rr_b_s;
          state_d = idle_next_s;
        end else if (timeout_a_s) begin
          arb_b_s = 1'b1;
          state_d = IDLE;
        end else begin
          arb_a_s = a_req;
          state_d = LOCK_A;
        end
      end
      LOCK_B: begin
        if (!b_lock) begin
          arb_a_s = rr_a_s;
          arb_b_s = rr_b_s;
          state_d = idle_next_s;
        end else if (timeout_b_s) begin
          arb_a_s = 1'b1;
          state_d = IDLE;
        end else begin
          arb_b_s = b_req;
          state_d = LOCK_B;
        end
      end
      default: begin
        arb_a_s = 1'b0;
        arb_b_s = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Grants are suppressed while reset is asserted so the port stays quiet.
    gnt_a_s = arb_a_s && rst_n;
    gnt_b_s = arb_b_s && rst_n;
  end

  // Lock-duration counter: counts locked cycles in which the other side waits.
  always_comb begin
    if ((state_q == LOCK_A) && (state_d == LOCK_A) && b_req) begin
      lock_cnt_d = sat_inc16(lock_cnt_q);
    end else if ((state_q == LOCK_B) && (state_d == LOCK_B) && a_req) begin
      lock_cnt_d = sat_inc16(lock_cnt_q);
    end else begin
      lock_cnt_d = 16'd0;
    end
  end

  // Memory port mux and winner bookkeeping; address/data hold when idle.
  always_comb begin
    if (gnt_a_s) begin
      we_s          = a_we;
      addr_d        = a_addr;
      dw_d          = a_wdata;
      last_winner_d = ID_A;
    end else if (gnt_b_s) begin
      we_s          = b_we;
      addr_d        = b_addr;
      dw_d          = b_wdata;
      last_winner_d = ID_B;
    end else begin
      we_s          = 1'b0;
      addr_d        = addr_q;
      dw_d          = dw_q;
      last_winner_d = last_winner_q;
    end

    a_gnt    = gnt_a_s;
    b_gnt    = gnt_b_s;
    mem_en   = gnt_a_s || gnt_b_s;
    mem_we   = we_s;
    mem_addr = addr_d;
    mem_dw   = dw_d;

    tag_in_s.valid = (gnt_a_s || gnt_b_s) && !we_s;
    tag_in_s.id    = gnt_b_s ? ID_B : ID_A;
  end

  rd_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in_s),
    .tag_out (tag_out_s)
  );

  // Read return: steer mem_dr to the issuer; the other side keeps its data.
  always_comb begin
    a_rvalid = tag_out_s.valid && (tag_out_s.id == ID_A);
    b_rvalid = tag_out_s.valid && (tag_out_s.id == ID_B);

    if (a_rvalid) begin
      a_rdata_d = mem_dr;
    end else begin
      a_rdata_d = a_rdata_q;
    end

    if (b_rvalid) begin
      b_rdata_d = mem_dr;
    end else begin
      b_rdata_d = b_rdata_q;
    end

    a_rdata = a_rdata_d;
    b_rdata = b_rdata_d;
  end

  // Conflict counter: any cycle with a pending, ungranted request.
  always_comb begin
    if ((a_req && !gnt_a_s) || (b_req && !gnt_b_s)) begin
      conflict_cnt_d = sat_inc16(conflict_cnt_q);
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
    conflict_cnt = conflict_cnt_q;
  end

  // Arbiter state; B is recorded as last winner so A takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_winner_q  <= ID_B;
      lock_cnt_q     <= 16'd0;
      conflict_cnt_q <= 16'd0;
      addr_q         <= {ADDR_WIDTH{1'b0}};
      dw_q           <= {DATA_WIDTH{1'b0}};
      a_rdata_q      <= {DATA_WIDTH{1'b0}};
      b_rdata_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      last_winner_q  <= last_winner_d;
      lock_cnt_q     <= lock_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
      addr_q         <= addr_d;
      dw_q           <= dw_d;
      a_rdata_q      <= a_rdata_d;
      b_rdata_q      <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 / no timeout, and
// latency 3 / timeout 3) share stimulus; directed vectors with a read-return
// scoreboard checked by an independent monitor.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req, a_lock, a_we, b_req, b_lock, b_we;
  logic [15:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic        a_gnt [2];
  logic        b_gnt [2];
  logic        a_rvalid [2];
  logic        b_rvalid [2];
  logic [31:0] a_rdata [2];
  logic [31:0] b_rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [15:0] mem_addr [2];
  logic [31:0] mem_dw [2];
  logic [31:0] mem_dr [2];
  logic [15:0] conflict_cnt [2];

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   sel = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_LATENCY(1), .LOCK_TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_dw(mem_dw[0]),
    .mem_dr(mem_dr[0]), .conflict_cnt(conflict_cnt[0]));

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_LATENCY(3), .LOCK_TIMEOUT(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_dw(mem_dw[1]),
    .mem_dr(mem_dr[1]), .conflict_cnt(conflict_cnt[1]));

  // Unwritten memory locations read back as A5A5_<addr>.
  function automatic logic [31:0] pat(input logic [15:0] a);
    return {16'hA5A5, a};
  endfunction

  // Memory models: write at the edge, read data appears LAT cycles later.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] store [4096];
    bit          written [4096];
    logic [31:0] pipe [4];

    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) begin
        store[mem_addr[g][11:0]]   <= mem_dw[g];
        written[mem_addr[g][11:0]] <= 1'b1;
      end
      if (mem_en[g] && !mem_we[g]) begin
        pipe[0] <= written[mem_addr[g][11:0]] ? store[mem_addr[g][11:0]] : pat(mem_addr[g]);
      end else begin
        pipe[0] <= 32'hBAD0_BAD0;
      end
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_dr[g] = pipe[LAT-1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  logic        mon_av, mon_bv;
  logic [31:0] mon_ad, mon_bd;
  assign mon_av = (sel == 0) ? a_rvalid[0] : a_rvalid[1];
  assign mon_bv = (sel == 0) ? b_rvalid[0] : b_rvalid[1];
  assign mon_ad = (sel == 0) ? a_rdata[0] : a_rdata[1];
  assign mon_bd = (sel == 0) ? b_rdata[0] : b_rdata[1];

  // Monitor: every rvalid must match the oldest expected return for that side.
  always @(negedge clk) begin
    if (mon_av) begin
      if (qa.size() == 0) chk("a_rvalid_unexpected", {31'd0, mon_av}, 32'd0);
      else begin
        ea = qa.pop_front();
        chk("a_rdata", mon_ad, ea.data);
        chk("a_rvalid_cycle", cyc, ea.cyc);
      end
    end
    if (mon_bv) begin
      if (qb.size() == 0) chk("b_rvalid_unexpected", {31'd0, mon_bv}, 32'd0);
      else begin
        eb = qb.pop_front();
        chk("b_rdata", mon_bd, eb.data);
        chk("b_rvalid_cycle", cyc, eb.cyc);
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); endtask

  task automatic clr();
    a_req = 1'b0; a_lock = 1'b0; a_we = 1'b0; a_addr = 16'h0000; a_wdata = 32'h0;
    b_req = 1'b0; b_lock = 1'b0; b_we = 1'b0; b_addr = 16'h0000; b_wdata = 32'h0;
  endtask

  // Pulse reset for two cycles; returns at the start of the first live cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clr();
    tick();

    // ---- Tie after reset: A wins, B next; both reads return in order ----
    sel = 0;
    do_reset();
    a_req = 1'b1; a_addr = 16'h0010; b_req = 1'b1; b_addr = 16'h0020;
    qa.push_back('{data: 32'hA5A5_0010, cyc: cyc + 1});
    mid();
    chk("t1_a_gnt", {31'd0, a_gnt[0]}, 32'd1);
    chk("t1_b_denied", {31'd0, b_gnt[0]}, 32'd0);
    chk("t1_mem_addr", {16'd0, mem_addr[0]}, 32'h0010);
    tick();
    a_req = 1'b0;
    qb.push_back('{data: 32'hA5A5_0020, cyc: cyc + 1});
    mid();
    chk("t1_b_gnt", {31'd0, b_gnt[0]}, 32'd1);
    chk("t1_a_no_gnt", {31'd0, a_gnt[0]}, 32'd0);
    tick();
    b_req = 1'b0;
    mid();
    chk("t1_idle_mem_en", {31'd0, mem_en[0]}, 32'd0);
    chk("t1_idle_addr_hold", {16'd0, mem_addr[0]}, 32'h0020);
    chk("t1_conflict", {16'd0, conflict_cnt[0]}, 32'd1);
    tick();
    mid();
    chk("t1_a_rdata_hold", a_rdata[0], 32'hA5A5_0010);

    // ---- Write by A, read-after-write by B next cycle ----
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0100; a_wdata = 32'hDEAD_BEEF;
    mid();
    chk("t2_a_gnt", {31'd0, a_gnt[0]}, 32'd1);
    chk("t2_mem_we", {31'd0, mem_we[0]}, 32'd1);
    chk("t2_mem_dw", mem_dw[0], 32'hDEAD_BEEF);
    tick();
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b1; b_addr = 16'h0100;
    qb.push_back('{data: 32'hDEAD_BEEF, cyc: cyc + 1});
    mid();
    chk("t2_b_gnt", {31'd0, b_gnt[0]}, 32'd1);
    tick();
    b_req = 1'b0;
    mid();
    tick();
    chk("t2_qb_drained", qb.size(), 32'd0);

    // ---- A locks with no timeout: B starved until lock drops ----
    do_reset();
    a_req = 1'b1; a_lock = 1'b1; a_we = 1'b1; a_addr = 16'h0200; a_wdata = 32'h1;
    mid();
    chk("t3_lock_gnt", {31'd0, a_gnt[0]}, 32'd1);
    tick();
    a_req = 1'b0; b_req = 1'b1; b_addr = 16'h0030;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t3_b_starved", {31'd0, b_gnt[0]}, 32'd0);
      chk("t3_mem_en_off", {31'd0, mem_en[0]}, 32'd0);
      tick();
    end
    a_lock = 1'b0;
    qb.push_back('{data: 32'hA5A5_0030, cyc: cyc + 1});
    mid();
    chk("t3_b_gnt_on_unlock", {31'd0, b_gnt[0]}, 32'd1);
    chk("t3_conflict5", {16'd0, conflict_cnt[0]}, 32'd5);
    tick();
    b_req = 1'b0;
    mid();
    chk("t3_conflict_stays", {16'd0, conflict_cnt[0]}, 32'd5);
    tick();
    chk("t3_qb_drained", qb.size(), 32'd0);

    // ---- Timeout 3: B forced through on the 4th contention cycle ----
    sel = 1;
    do_reset();
    a_req = 1'b1; a_lock = 1'b1; a_we = 1'b1; a_addr = 16'h0040; a_wdata = 32'h2;
    mid();
    chk("t4_lock_gnt", {31'd0, a_gnt[1]}, 32'd1);
    tick();
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0050; b_wdata = 32'h3;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t4_a_keeps", {31'd0, a_gnt[1]}, 32'd1);
      chk("t4_b_waits", {31'd0, b_gnt[1]}, 32'd0);
      tick();
    end
    mid();
    chk("t4_b_timeout_gnt", {31'd0, b_gnt[1]}, 32'd1);
    chk("t4_a_preempted", {31'd0, a_gnt[1]}, 32'd0);
    tick();
    a_req = 1'b0;
    mid();
    chk("t4_idle_after_timeout", {31'd0, b_gnt[1]}, 32'd1);
    tick();

    // ---- Latency 3, alternating reads, reset drops in-flight ones ----
    do_reset();
    a_req = 1'b1; a_addr = 16'h0060;
    qa.push_back('{data: 32'hA5A5_0060, cyc: cyc + 3});
    mid();
    chk("t5_a_gnt0", {31'd0, a_gnt[1]}, 32'd1);
    tick();
    a_req = 1'b0; b_req = 1'b1; b_addr = 16'h0070;
    qb.push_back('{data: 32'hA5A5_0070, cyc: cyc + 3});
    mid();
    chk("t5_b_gnt1", {31'd0, b_gnt[1]}, 32'd1);
    tick();
    b_req = 1'b0; a_req = 1'b1; a_addr = 16'h0080;
    mid();
    tick();
    a_req = 1'b0; b_req = 1'b1; b_addr = 16'h0090;
    mid();
    tick();
    b_req = 1'b0;
    mid();
    tick();
    rst_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    mid();
    chk("t5_rst_a_gnt", {31'd0, a_gnt[1]}, 32'd0);
    chk("t5_rst_b_gnt", {31'd0, b_gnt[1]}, 32'd0);
    chk("t5_rst_mem_en", {31'd0, mem_en[1]}, 32'd0);
    chk("t5_rst_mem_we", {31'd0, mem_we[1]}, 32'd0);
    chk("t5_rst_mem_addr", {16'd0, mem_addr[1]}, 32'd0);
    chk("t5_rst_mem_dw", mem_dw[1], 32'd0);
    chk("t5_rst_a_rvalid", {31'd0, a_rvalid[1]}, 32'd0);
    chk("t5_rst_b_rvalid", {31'd0, b_rvalid[1]}, 32'd0);
    chk("t5_rst_a_rdata", a_rdata[1], 32'd0);
    chk("t5_rst_b_rdata", b_rdata[1], 32'd0);
    chk("t5_rst_conflict", {16'd0, conflict_cnt[1]}, 32'd0);
    tick();
    tick();
    clr();
    rst_n = 1'b1;
    repeat (6) begin
      mid();
      tick();
    end
    chk("t5_qa_drained", qa.size(), 32'd0);
    chk("t5_qb_drained", qb.size(), 32'd0);

    // ---- Conflict counter saturation ----
    sel = 0;
    do_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0300;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0301;
    for (int k = 0; k <= 65537; k++) begin
      mid();
      if (k == 65534) chk("t6_cnt_fffe", {16'd0, conflict_cnt[0]}, 32'h0000_FFFE);
      if (k == 65535) chk("t6_cnt_ffff", {16'd0, conflict_cnt[0]}, 32'h0000_FFFF);
      if (k == 65537) chk("t6_cnt_saturated", {16'd0, conflict_cnt[0]}, 32'h0000_FFFF);
      tick();
    end
    clr();
    mid();
    tick();
    chk("end_qa_empty", qa.size(), 32'd0);
    chk("end_qb_empty", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
